// File: rtl/spi_wb_pkg.sv
// Shared register map, bit positions and helpers for the SPI slave with register-bus front end.
// Imported by the interface, the top level and the slave core.
package spi_wb_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 2;

  typedef enum logic [ADDR_WIDTH-1:0] {
    ADDR_SPCR = 2'd0,
    ADDR_SPSR = 2'd1,
    ADDR_SPDR = 2'd2,
    ADDR_SPER = 2'd3
  } reg_addr_e;

  localparam int SPCR_SPIE = 7;
  localparam int SPCR_SPE  = 6;
  localparam int SPCR_MSTR = 5;
  localparam int SPCR_CPOL = 4;
  localparam int SPCR_CPHA = 3;

  localparam int SPSR_SPIF = 7;
  localparam int SPSR_WCOL = 6;
  localparam int SPSR_BUSY = 0;

  localparam int SPER_LSB  = 0;

  // Bit presented on miso for a given shift register and bit order.
  function automatic logic spi_bit_out(logic [DATA_WIDTH-1:0] sh, logic lsb_first);
    return lsb_first ? sh[0] : sh[DATA_WIDTH-1];
  endfunction

endpackage

// File: rtl/spi_wb_combine_if.sv
// SPI pins, register bus and parallel user port of spi_wb_combine bundled together.
// The master modport is the surrounding system; the slave modport is the block itself.
interface spi_wb_combine_if;
  import spi_wb_pkg::*;

  logic                  sck;
  logic                  ssn_i;
  logic                  mosi;
  logic                  miso;

  logic                  stb_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  ack_o;
  logic                  int_o;

  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] rx_data;

  modport master (
    output sck, ssn_i, mosi, stb_i, we_i, addr_i, data_i, tx_valid, tx_data,
    input  miso, data_o, ack_o, int_o, rx_valid, rx_data
  );

  modport slave (
    input  sck, ssn_i, mosi, stb_i, we_i, addr_i, data_i, tx_valid, tx_data,
    output miso, data_o, ack_o, int_o, rx_valid, rx_data
  );

endinterface

// File: rtl/spi_slave_core.sv
// SPI slave datapath: pin synchronizers, sck edge detect, TX buffer, shift registers, bit counter.
// Mode and bit order are latched at each byte start so mid-byte register changes wait for the next byte.
module spi_slave_core
  import spi_wb_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sck_i,
  input  logic                  ssn_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  input  logic                  spe_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  lsb_first_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_dat_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  busy_o,
  output logic                  wcol_o
);

  logic [1:0] sck_sync_q, ssn_sync_q, mosi_sync_q;
  logic       sck_prev_q;
  logic       active_q, active_d;
  logic       cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic [DATA_WIDTH-1:0] txbuf_q, txbuf_d, txsh_q, txsh_d, rxsh_q, rxsh_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d, rx_next;
  logic       txfull_q, txfull_d;
  logic [2:0] cnt_q, cnt_d;
  logic       seen_q, seen_d;
  logic       rx_valid_q, rx_valid_d, wcol_q, wcol_d, miso_q, miso_d;

  logic sck_s, ssn_s, mosi_s, active, rise, fall, lead, trail;
  logic sample_e, shift_e, done, byte_start;

  assign sck_s  = sck_sync_q[1];
  assign ssn_s  = ssn_sync_q[1];
  assign mosi_s = mosi_sync_q[1];
  assign active = spe_i & ~ssn_s;

  assign rise  = sck_s & ~sck_prev_q;
  assign fall  = ~sck_s & sck_prev_q;
  assign lead  = cpol_q ? fall : rise;
  assign trail = cpol_q ? rise : fall;

  // cnt_q counts samples taken; no shift before the first sample keeps bit 0 on the wire.
  assign sample_e   = active_q & active & (cpha_q ? trail : lead);
  assign shift_e    = active_q & active & (cpha_q ? lead : trail) & (cnt_q != 3'd0);
  assign done       = sample_e & (cnt_q == 3'd7);
  assign byte_start = (active & ~active_q) | done;
  assign rx_next    = lsb_q ? {mosi_s, rxsh_q[DATA_WIDTH-1:1]} : {rxsh_q[DATA_WIDTH-2:0], mosi_s};

  always_comb begin
    active_d   = active;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    txbuf_d    = txbuf_q;
    txfull_d   = txfull_q;
    txsh_d     = txsh_q;
    rxsh_d     = rxsh_q;
    cnt_d      = cnt_q;
    seen_d     = seen_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    wcol_d     = 1'b0;

    if (load_i) begin
      txbuf_d  = load_dat_i;
      txfull_d = 1'b1;
      wcol_d   = txfull_q;
    end

    if (!active) begin
      cnt_d  = 3'd0;
      seen_d = 1'b0;
      txsh_d = '0;
      rxsh_d = '0;
    end else if (byte_start) begin
      cpol_d   = cpol_i;
      cpha_d   = cpha_i;
      lsb_d    = lsb_first_i;
      txsh_d   = txfull_d ? txbuf_d : '0;
      txfull_d = 1'b0;
      cnt_d    = 3'd0;
      seen_d   = 1'b0;
      rxsh_d   = '0;
      if (done) begin
        rx_data_d  = rx_next;
        rx_valid_d = 1'b1;
      end
    end else begin
      if (lead) seen_d = 1'b1;
      if (sample_e) begin
        rxsh_d = rx_next;
        cnt_d  = cnt_q + 3'd1;
      end
      if (shift_e) txsh_d = lsb_q ? {1'b0, txsh_q[DATA_WIDTH-1:1]} : {txsh_q[DATA_WIDTH-2:0], 1'b0};
      // Before the first edge of a byte a fresh load goes straight onto the wire.
      if (load_i && !seen_q) begin
        txsh_d   = load_dat_i;
        txfull_d = 1'b0;
      end
    end

    miso_d = active ? spi_bit_out(txsh_d, lsb_d) : 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_sync_q  <= '0;
      ssn_sync_q  <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      active_q    <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
      txbuf_q     <= '0;
      txfull_q    <= 1'b0;
      txsh_q      <= '0;
      rxsh_q      <= '0;
      cnt_q       <= 3'd0;
      seen_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      wcol_q      <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], sck_i};
      ssn_sync_q  <= {ssn_sync_q[0], ssn_i};
      mosi_sync_q <= {mosi_sync_q[0], mosi_i};
      sck_prev_q  <= sck_s;
      active_q    <= active_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      lsb_q       <= lsb_d;
      txbuf_q     <= txbuf_d;
      txfull_q    <= txfull_d;
      txsh_q      <= txsh_d;
      rxsh_q      <= rxsh_d;
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      wcol_q      <= wcol_d;
      miso_q      <= miso_d;
    end
  end

  assign miso_o     = miso_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = seen_q;
  assign wcol_o     = wcol_q;

endmodule

// File: rtl/spi_wb_combine.sv
// SPI slave with a 4-register bus front end; registers, flags and interrupt live here.
// Bus ack is one cycle after the strobe is seen; the reset is released through a 2-flop synchronizer.
module spi_wb_combine
  import spi_wb_pkg::*;
(
  input  logic            clk_i,
  input  logic            rstn_i,
  spi_wb_combine_if.slave bus
);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [DATA_WIDTH-1:0] spcr_q, spcr_d, dat_q, dat_d;
  logic spif_q, spif_d, wcol_q, wcol_d, lsb_q, lsb_d;
  logic ack_q, ack_d, int_q, int_d;

  logic acc, wr, spdr_wr, tx_load;
  logic [DATA_WIDTH-1:0] tx_load_dat, core_rx_data;
  logic core_rx_valid, core_busy, core_wcol, core_miso;

  assign acc         = bus.stb_i & ~ack_q;
  assign wr          = acc & bus.we_i;
  assign spdr_wr     = wr & (bus.addr_i == ADDR_SPDR);
  assign tx_load     = bus.tx_valid | spdr_wr;
  assign tx_load_dat = bus.tx_valid ? bus.tx_data : bus.data_i;

  spi_slave_core u_core (
    .clk_i       (clk_i),
    .rst_ni      (rst_n),
    .sck_i       (bus.sck),
    .ssn_i       (bus.ssn_i),
    .mosi_i      (bus.mosi),
    .miso_o      (core_miso),
    .spe_i       (spcr_q[SPCR_SPE]),
    .cpol_i      (spcr_q[SPCR_CPOL]),
    .cpha_i      (spcr_q[SPCR_CPHA]),
    .lsb_first_i (lsb_q),
    .load_i      (tx_load),
    .load_dat_i  (tx_load_dat),
    .rx_data_o   (core_rx_data),
    .rx_valid_o  (core_rx_valid),
    .busy_o      (core_busy),
    .wcol_o      (core_wcol)
  );

  always_comb begin
    spcr_d = spcr_q;
    spif_d = spif_q;
    wcol_d = wcol_q;
    lsb_d  = lsb_q;
    dat_d  = dat_q;
    ack_d  = acc;

    if (acc) begin
      case (reg_addr_e'(bus.addr_i))
        ADDR_SPCR: dat_d = spcr_q;
        ADDR_SPSR: dat_d = {spif_q, wcol_q, 5'b00000, core_busy};
        ADDR_SPDR: dat_d = core_rx_data;
        default:   dat_d = {7'b0000000, lsb_q};
      endcase
    end

    if (wr) begin
      case (reg_addr_e'(bus.addr_i))
        ADDR_SPCR: spcr_d = bus.data_i;
        ADDR_SPSR: begin
          if (bus.data_i[SPSR_SPIF]) spif_d = 1'b0;
          if (bus.data_i[SPSR_WCOL]) wcol_d = 1'b0;
        end
        ADDR_SPER: lsb_d = bus.data_i[SPER_LSB];
        default: ;
      endcase
    end

    // A hardware set in the same cycle as a software clear must survive.
    if (core_rx_valid) spif_d = 1'b1;
    if (core_wcol)     wcol_d = 1'b1;

    int_d = spcr_q[SPCR_SPIE] & spif_q;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      spcr_q <= '0;
      spif_q <= 1'b0;
      wcol_q <= 1'b0;
      lsb_q  <= 1'b0;
      dat_q  <= '0;
      ack_q  <= 1'b0;
      int_q  <= 1'b0;
    end else begin
      spcr_q <= spcr_d;
      spif_q <= spif_d;
      wcol_q <= wcol_d;
      lsb_q  <= lsb_d;
      dat_q  <= dat_d;
      ack_q  <= ack_d;
      int_q  <= int_d;
    end
  end

  assign bus.miso     = core_miso;
  assign bus.data_o   = dat_q;
  assign bus.ack_o    = ack_q;
  assign bus.int_o    = int_q;
  assign bus.rx_valid = core_rx_valid;
  assign bus.rx_data  = core_rx_data;

endmodule

// File: tb/tb_spi_wb_combine.sv
// Directed bench for spi_wb_combine: register access, all four SPI modes, bit order, abort, WCOL, reset.
module tb_spi_wb_combine;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  spi_wb_combine_if bus ();

  spi_wb_combine dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int rxv_cnt = 0;
  logic [7:0] rx_cap = 8'h00;

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      rxv_cnt++;
      rx_cap = bus.rx_data;
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    bus.stb_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = a; bus.data_i = d;
    @(negedge clk);
    chk("wr_ack", {7'b0, bus.ack_o}, 8'h01);
    bus.stb_i = 1'b0; bus.we_i = 1'b0;
    @(negedge clk);
    chk("wr_ack_drop", {7'b0, bus.ack_o}, 8'h00);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    bus.stb_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = a;
    @(negedge clk);
    chk("rd_ack", {7'b0, bus.ack_o}, 8'h01);
    d = bus.data_o;
    bus.stb_i = 1'b0;
    @(negedge clk);
    chk("rd_ack_drop", {7'b0, bus.ack_o}, 8'h00);
  endtask

  // SPI master: half period of 8 clk cycles, nbits bits, miso captured on the master's sample edge.
  task automatic spi_bits(input logic cpol, input logic cpha, input logic lsb, input logic [7:0] tx,
                          input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      int b;
      b = lsb ? i : 7 - i;
      if (!cpha) begin
        bus.mosi = tx[b];
        cyc(8);
        bus.sck = ~cpol;
        rx[b] = bus.miso;
        cyc(8);
        bus.sck = cpol;
      end else begin
        bus.sck = ~cpol;
        bus.mosi = tx[b];
        cyc(8);
        bus.sck = cpol;
        rx[b] = bus.miso;
        cyc(8);
      end
    end
  endtask

  logic [7:0] rd, got;
  int base;

  initial begin
    bus.sck = 1'b0; bus.ssn_i = 1'b1; bus.mosi = 1'b0;
    bus.stb_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = 2'd0; bus.data_i = 8'h00;
    bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
    #2 rstn = 1'b0;
    cyc(3);
    chk("rst_data_o",   bus.data_o, 8'h00);
    chk("rst_ack_o",    {7'b0, bus.ack_o}, 8'h00);
    chk("rst_int_o",    {7'b0, bus.int_o}, 8'h00);
    chk("rst_miso",     {7'b0, bus.miso}, 8'h00);
    chk("rst_rx_valid", {7'b0, bus.rx_valid}, 8'h00);
    chk("rst_rx_data",  bus.rx_data, 8'h00);
    rstn = 1'b1;
    cyc(4);

    // Held strobe gives alternating acks.
    bus.stb_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 2'd0;
    cyc(1); chk("hold_ack0", {7'b0, bus.ack_o}, 8'h01);
    cyc(1); chk("hold_ack1", {7'b0, bus.ack_o}, 8'h00);
    cyc(1); chk("hold_ack2", {7'b0, bus.ack_o}, 8'h01);
    cyc(1); chk("hold_ack3", {7'b0, bus.ack_o}, 8'h00);
    bus.stb_i = 1'b0;
    cyc(1);

    // Register access and mode 2 two-byte exchange.
    bus.sck = 1'b1;
    bus_write(2'd0, 8'hD3);
    bus_read(2'd0, rd);
    chk("spcr_readback", rd, 8'hD3);
    base = rxv_cnt;
    bus.ssn_i = 1'b0; bus.tx_valid = 1'b1; bus.tx_data = 8'h45;
    cyc(1);
    bus.tx_valid = 1'b0;
    cyc(8);
    spi_bits(1'b1, 1'b0, 1'b0, 8'h91, 8, got);
    chk("m2_miso0", got, 8'h45);
    chk("m2_rxcnt0", 8'(rxv_cnt - base), 8'h01);
    chk("m2_rx0", rx_cap, 8'h91);
    bus.tx_valid = 1'b1; bus.tx_data = 8'hB4;
    cyc(1);
    bus.tx_valid = 1'b0;
    cyc(4);
    spi_bits(1'b1, 1'b0, 1'b0, 8'hB6, 8, got);
    cyc(4);
    chk("m2_miso1", got, 8'hB4);
    chk("m2_rxcnt1", 8'(rxv_cnt - base), 8'h02);
    chk("m2_rx1", rx_cap, 8'hB6);
    chk("m2_rx_data", bus.rx_data, 8'hB6);
    bus_read(2'd1, rd);
    chk("m2_spsr", rd, 8'h80);
    chk("m2_int", {7'b0, bus.int_o}, 8'h01);
    bus.ssn_i = 1'b1;
    cyc(4);
    bus_write(2'd1, 8'h80);
    cyc(2);
    chk("spif_clr_int", {7'b0, bus.int_o}, 8'h00);

    // Modes 0, 1, 3: master sends A5, slave returns 3C.
    for (int m = 0; m < 4; m++) begin
      logic cpol, cpha;
      if (m == 2) continue;
      cpol = m[1];
      cpha = m[0];
      bus.sck = cpol;
      bus_write(2'd0, {2'b01, 1'b0, cpol, cpha, 3'b000});
      bus_write(2'd2, 8'h3C);
      base = rxv_cnt;
      bus.ssn_i = 1'b0;
      cyc(8);
      spi_bits(cpol, cpha, 1'b0, 8'hA5, 8, got);
      cyc(4);
      chk($sformatf("mode%0d_miso", m), got, 8'h3C);
      chk($sformatf("mode%0d_rx", m), rx_cap, 8'hA5);
      chk($sformatf("mode%0d_rxcnt", m), 8'(rxv_cnt - base), 8'h01);
      bus.ssn_i = 1'b1;
      cyc(4);
    end

    // LSB first in both directions, mode 0.
    bus.sck = 1'b0;
    bus_write(2'd0, 8'h40);
    bus_write(2'd3, 8'h01);
    bus.tx_valid = 1'b1; bus.tx_data = 8'h80;
    cyc(1);
    bus.tx_valid = 1'b0;
    bus.ssn_i = 1'b0;
    cyc(8);
    spi_bits(1'b0, 1'b0, 1'b1, 8'h01, 8, got);
    cyc(4);
    chk("lsb_rx", bus.rx_data, 8'h01);
    chk("lsb_miso", got, 8'h80);
    bus.ssn_i = 1'b1;
    cyc(4);
    bus_write(2'd3, 8'h00);

    // Abort after 4 bits, then a full byte.
    base = rxv_cnt;
    bus.ssn_i = 1'b0;
    cyc(8);
    spi_bits(1'b0, 1'b0, 1'b0, 8'hF0, 4, got);
    cyc(4);
    bus_read(2'd1, rd);
    chk("abort_busy", rd & 8'h01, 8'h01);
    bus.ssn_i = 1'b1;
    cyc(12);
    chk("abort_no_rxv", 8'(rxv_cnt - base), 8'h00);
    chk("abort_rx_kept", bus.rx_data, 8'h01);
    bus.ssn_i = 1'b0;
    cyc(8);
    spi_bits(1'b0, 1'b0, 1'b0, 8'h5A, 8, got);
    cyc(4);
    chk("after_abort_rx", bus.rx_data, 8'h5A);
    chk("after_abort_rxcnt", 8'(rxv_cnt - base), 8'h01);
    bus.ssn_i = 1'b1;
    cyc(4);

    // Write collision and its clear.
    bus_write(2'd2, 8'h11);
    bus_write(2'd2, 8'h22);
    bus_read(2'd1, rd);
    chk("wcol_set", rd & 8'h40, 8'h40);
    bus_write(2'd1, 8'h40);
    bus_read(2'd1, rd);
    chk("wcol_clr", rd & 8'h40, 8'h00);

    // Reset in the middle of a byte.
    bus.ssn_i = 1'b0;
    cyc(8);
    spi_bits(1'b0, 1'b0, 1'b0, 8'hC3, 3, got);
    rstn = 1'b0;
    #1;
    chk("mid_rst_data_o",   bus.data_o, 8'h00);
    chk("mid_rst_ack_o",    {7'b0, bus.ack_o}, 8'h00);
    chk("mid_rst_int_o",    {7'b0, bus.int_o}, 8'h00);
    chk("mid_rst_miso",     {7'b0, bus.miso}, 8'h00);
    chk("mid_rst_rx_valid", {7'b0, bus.rx_valid}, 8'h00);
    chk("mid_rst_rx_data",  bus.rx_data, 8'h00);
    cyc(2);
    bus.ssn_i = 1'b1;
    rstn = 1'b1;
    cyc(4);
    bus_read(2'd0, rd);
    chk("post_rst_spcr", rd, 8'h00);
    bus_read(2'd1, rd);
    chk("post_rst_spsr", rd, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
